// File: rtl/camera_pkg.sv
// Shared types and geometry for the camera readout path.
package camera_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned COLS   = 2;
  localparam int unsigned ROWS   = 2;
  localparam int unsigned CNT_W  = 8;

  localparam int unsigned PIXELS = ROWS * COLS;
  localparam int unsigned IDX_W  = $clog2(PIXELS);
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned COL_W  = $clog2(COLS);

  typedef logic [DATA_W-1:0] pixel_t;

  typedef enum logic {
    CAPTURE,
    DRAIN
  } readout_state_t;

endpackage

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector; Rise_c is high for the first cycle Sig is seen high.
module edge_detect_rise (
  input  logic Clk,
  input  logic Reset,
  input  logic Sig,
  output logic Rise_c
);

  logic sig_q;

  always_ff @(posedge Clk) begin
    if (Reset) sig_q <= 1'b0;
    else       sig_q <= Sig;
  end

  assign Rise_c = Sig && !sig_q;

endmodule

// File: rtl/frame_readout_buffer.sv
// Captures one row of column samples per ADC strobe, then drains the full
// frame as a raster-order valid/ready pixel stream.
module frame_readout_buffer
  import camera_pkg::*;
(
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     NRE_1,
  input  logic                     NRE_2,
  input  logic                     ADC,
  input  logic                     Erase,
  input  logic [DATA_W*COLS-1:0]   Pixel_data,
  output logic [DATA_W-1:0]        Out_data,
  output logic                     Out_valid,
  input  logic                     Out_ready,
  output logic                     Out_last,
  output logic [CNT_W-1:0]         Frame_count,
  output logic                     Overrun,
  output logic                     Seq_error
);

  readout_state_t   state, state_n;
  logic [ROWS-1:0]  mask, mask_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] count_n;
  logic             overrun_n, seq_n;
  logic             strobe;
  logic             row0_req, row1_req, sel_ok;
  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [ROWS-1:0]  wr_bit;
  logic [ROW_W-1:0] row_sel;
  logic [COL_W-1:0] col_sel;

  pixel_t frame_buf [ROWS][COLS];

  edge_detect_rise u_adc_edge (
    .Clk    (Clk),
    .Reset  (Reset),
    .Sig    (ADC),
    .Rise_c (strobe)
  );

  // Exactly one of the active-low row enables must be asserted for a valid capture
  assign row0_req = !NRE_1 &&  NRE_2;
  assign row1_req =  NRE_1 && !NRE_2;
  assign sel_ok   = row0_req || row1_req;
  assign wr_row   = ROW_W'(row1_req);
  assign wr_bit   = ROWS'(1) << wr_row;

  always_comb begin
    state_n   = state;
    mask_n    = mask;
    idx_n     = idx;
    count_n   = Frame_count;
    overrun_n = Overrun;
    seq_n     = Seq_error | (strobe && !sel_ok);
    wr_en     = 1'b0;
    case (state)
      CAPTURE: begin
        if (strobe && sel_ok) begin
          // A coincident Erase drops the old rows but keeps the new one
          wr_en  = 1'b1;
          mask_n = (Erase ? '0 : mask) | wr_bit;
          if (&mask_n) begin
            state_n = DRAIN;
            idx_n   = '0;
          end
        end else if (Erase && !strobe) begin
          mask_n = '0;
        end
      end
      DRAIN: begin
        overrun_n = Overrun | strobe;
        if (Out_ready) begin
          if (idx == IDX_W'(PIXELS - 1)) begin
            idx_n   = '0;
            mask_n  = '0;
            count_n = Frame_count + CNT_W'(1);
            state_n = CAPTURE;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      default: state_n = CAPTURE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= CAPTURE;
      mask        <= '0;
      idx         <= '0;
      Frame_count <= '0;
      Overrun     <= 1'b0;
      Seq_error   <= 1'b0;
    end else begin
      state       <= state_n;
      mask        <= mask_n;
      idx         <= idx_n;
      Frame_count <= count_n;
      Overrun     <= overrun_n;
      Seq_error   <= seq_n;
    end
  end

  // Frame storage carries no reset; contents only matter once every row is written
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      for (int c = 0; c < int'(COLS); c++) begin
        frame_buf[wr_row][c] <= Pixel_data[c*DATA_W +: DATA_W];
      end
    end
  end

  assign row_sel   = ROW_W'(idx / IDX_W'(COLS));
  assign col_sel   = COL_W'(idx % IDX_W'(COLS));
  assign Out_valid = (state == DRAIN);
  assign Out_last  = Out_valid && (idx == IDX_W'(PIXELS - 1));
  assign Out_data  = Out_valid ? frame_buf[row_sel][col_sel] : '0;

endmodule

// File: tb/tb_frame_readout_buffer.sv
// Bench for frame_readout_buffer: queue-based frame model checked every cycle plus directed literal checks.
module tb_frame_readout_buffer;

  logic        Clk = 1'b0;
  logic        Reset, NRE_1, NRE_2, ADC, Erase, Out_ready;
  logic [15:0] Pixel_data;
  logic [7:0]  Out_data;
  logic        Out_valid, Out_last, Overrun, Seq_error;
  logic [7:0]  Frame_count;

  int checks = 0;
  int errors = 0;

  frame_readout_buffer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .NRE_1       (NRE_1),
    .NRE_2       (NRE_2),
    .ADC         (ADC),
    .Erase       (Erase),
    .Pixel_data  (Pixel_data),
    .Out_data    (Out_data),
    .Out_valid   (Out_valid),
    .Out_ready   (Out_ready),
    .Out_last    (Out_last),
    .Frame_count (Frame_count),
    .Overrun     (Overrun),
    .Seq_error   (Seq_error)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: row images, capture mask, pending pixel queue
  logic [15:0] m_rows [2];
  logic [1:0]  m_mask = '0;
  logic        m_adc_prev = 1'b0;
  bit          m_drain = 0;
  logic [7:0]  m_q [$];
  int          m_count = 0;
  bit          m_ovr = 0, m_seq = 0;
  bit          m_stb;
  int          m_r;
  logic [7:0]  log_q [$];

  always @(posedge Clk) begin
    if (Reset) begin
      m_mask = '0; m_adc_prev = 1'b0; m_drain = 0; m_q.delete();
      m_count = 0; m_ovr = 0; m_seq = 0;
    end else begin
      m_stb = ADC && !m_adc_prev;
      m_adc_prev = ADC;
      if (m_stb && (NRE_1 == NRE_2)) m_seq = 1;
      if (m_drain) begin
        if (m_stb) m_ovr = 1;
        if (Out_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_drain = 0; m_mask = '0; m_count = (m_count + 1) % 256;
          end
        end
      end else if (m_stb && (NRE_1 != NRE_2)) begin
        m_r = NRE_1 ? 1 : 0;
        m_rows[m_r] = Pixel_data;
        m_mask = Erase ? (2'b01 << m_r) : (m_mask | (2'b01 << m_r));
        if (m_mask == 2'b11) begin
          m_q.push_back(m_rows[0][7:0]);  m_q.push_back(m_rows[0][15:8]);
          m_q.push_back(m_rows[1][7:0]);  m_q.push_back(m_rows[1][15:8]);
          m_drain = 1;
        end
      end else if (Erase && !m_stb) begin
        m_mask = '0;
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of accepted pixels
  always @(negedge Clk) begin
    chk("valid", 32'(Out_valid), 32'(m_drain));
    if (m_drain && m_q.size() > 0) begin
      chk("data", 32'(Out_data), 32'(m_q[0]));
      chk("last", 32'(Out_last), 32'(m_q.size() == 1));
    end else begin
      chk("data_idle", 32'(Out_data), 32'h0);
      chk("last_idle", 32'(Out_last), 32'h0);
    end
    chk("frame_count", 32'(Frame_count), 32'(m_count));
    chk("overrun", 32'(Overrun), 32'(m_ovr));
    chk("seq_error", 32'(Seq_error), 32'(m_seq));
    if (Out_valid && Out_ready) log_q.push_back(Out_data);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One idle edge, then a single-cycle ADC pulse; returns just after the strobe edge
  task automatic strobe(input logic n1, input logic n2, input logic [15:0] d);
    tick();
    NRE_1 = n1; NRE_2 = n2; Pixel_data = d; ADC = 1'b1;
    tick();
    ADC = 1'b0; NRE_1 = 1'b1; NRE_2 = 1'b1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge Clk);
      if (!Out_valid) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: Out_valid still high after 40 cycles");
    end
    tick();
  endtask

  task automatic chk_log(input string name, input logic [7:0] e0, e1, e2, e3);
    chk({name, "_len"}, 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      chk({name, "_p0"}, 32'(log_q[0]), 32'(e0));
      chk({name, "_p1"}, 32'(log_q[1]), 32'(e1));
      chk({name, "_p2"}, 32'(log_q[2]), 32'(e2));
      chk({name, "_p3"}, 32'(log_q[3]), 32'(e3));
    end
    log_q.delete();
  endtask

  initial begin
    bit rdy_pat [7];
    rdy_pat = '{1, 0, 0, 1, 0, 1, 1};
    Reset = 1'b1; NRE_1 = 1'b1; NRE_2 = 1'b1; ADC = 1'b0; Erase = 1'b0;
    Out_ready = 1'b0; Pixel_data = '0;
    tick(); tick();
    Reset = 1'b0;
    chk("reset_valid", 32'(Out_valid), 32'h0);
    chk("reset_count", 32'(Frame_count), 32'h0);
    chk("reset_flags", 32'({Overrun, Seq_error}), 32'h0);

    // Basic frame, always ready
    Out_ready = 1'b1;
    strobe(1'b0, 1'b1, 16'h2211);
    chk("t1_no_drain_early", 32'(Out_valid), 32'h0);
    strobe(1'b1, 1'b0, 16'h4433);
    chk("t1_latency", 32'(Out_valid), 32'h1);
    wait_idle();
    chk_log("t1", 8'h11, 8'h22, 8'h33, 8'h44);
    chk("t1_count", 32'(Frame_count), 32'h1);

    // Backpressure pattern
    Out_ready = 1'b0;
    strobe(1'b0, 1'b1, 16'h2211);
    strobe(1'b1, 1'b0, 16'h4433);
    foreach (rdy_pat[i]) begin
      Out_ready = rdy_pat[i];
      tick();
    end
    Out_ready = 1'b1;
    wait_idle();
    chk_log("t2", 8'h11, 8'h22, 8'h33, 8'h44);
    chk("t2_count", 32'(Frame_count), 32'h2);

    // Erase discards a partial frame
    strobe(1'b0, 1'b1, 16'hAAAA);
    tick(); Erase = 1'b1; tick(); Erase = 1'b0;
    strobe(1'b1, 1'b0, 16'h5555);
    chk("t3_no_drain_after_one", 32'(Out_valid), 32'h0);
    strobe(1'b0, 1'b1, 16'h6666);
    chk("t3_drain", 32'(Out_valid), 32'h1);
    wait_idle();
    chk_log("t3", 8'h66, 8'h66, 8'h55, 8'h55);

    // Strobe during drain is dropped and flagged
    Out_ready = 1'b0;
    strobe(1'b0, 1'b1, 16'h0201);
    strobe(1'b1, 1'b0, 16'h0403);
    strobe(1'b0, 1'b1, 16'hFFFF);
    chk("t4_overrun", 32'(Overrun), 32'h1);
    Out_ready = 1'b1;
    wait_idle();
    chk_log("t4", 8'h01, 8'h02, 8'h03, 8'h04);

    // Sequencing errors keep the mask; held ADC yields one capture
    chk("t5_seq_before", 32'(Seq_error), 32'h0);
    strobe(1'b0, 1'b1, 16'h0A0B);
    strobe(1'b0, 1'b0, 16'hEEEE);
    strobe(1'b1, 1'b1, 16'hDDDD);
    chk("t5_seq_error", 32'(Seq_error), 32'h1);
    chk("t5_no_drain", 32'(Out_valid), 32'h0);
    strobe(1'b1, 1'b0, 16'h0C0D);
    wait_idle();
    chk_log("t5a", 8'h0B, 8'h0A, 8'h0D, 8'h0C);
    NRE_1 = 1'b0; NRE_2 = 1'b1; Pixel_data = 16'h1111; ADC = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      Pixel_data = Pixel_data + 16'h1111;
    end
    ADC = 1'b0; NRE_1 = 1'b1;
    chk("t5_hold_no_drain", 32'(Out_valid), 32'h0);
    strobe(1'b1, 1'b0, 16'h3333);
    wait_idle();
    chk_log("t5b", 8'h11, 8'h11, 8'h33, 8'h33);

    // Frame counter wrap, then reset mid-drain
    Reset = 1'b1; tick(); tick(); Reset = 1'b0;
    chk("t6_count_reset", 32'(Frame_count), 32'h0);
    for (int f = 0; f < 256; f++) begin
      strobe(1'b0, 1'b1, {8'(f), 8'(f)});
      strobe(1'b1, 1'b0, {8'(f + 1), 8'(f + 1)});
      wait_idle();
      if (f == 254) chk("t6_count_255", 32'(Frame_count), 32'hFF);
    end
    chk("t6_count_wrap", 32'(Frame_count), 32'h0);
    log_q.delete();
    strobe(1'b0, 1'b0, 16'h0000);
    chk("t6_seq", 32'(Seq_error), 32'h1);
    Out_ready = 1'b0;
    strobe(1'b0, 1'b1, 16'h0201);
    strobe(1'b1, 1'b0, 16'h0403);
    strobe(1'b0, 1'b1, 16'hFFFF);
    chk("t6_overrun", 32'(Overrun), 32'h1);
    Out_ready = 1'b1;
    tick(); tick();
    Reset = 1'b1; Out_ready = 1'b0;
    tick();
    chk("t6_abort_valid", 32'(Out_valid), 32'h0);
    chk("t6_abort_count", 32'(Frame_count), 32'h0);
    chk("t6_abort_flags", 32'({Overrun, Seq_error}), 32'h0);
    chk("t6_partial_len", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("t6_partial_p0", 32'(log_q[0]), 32'h01);
      chk("t6_partial_p1", 32'(log_q[1]), 32'h02);
    end
    Reset = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
